// File: rtl/top_md5_pkg.sv
// Shared opcodes, response values, FSM encoding and sizes for the top_md5
// host command path.
package top_md5_pkg;

  localparam logic [7:0] CMD_SET_HASH_OP   = 8'h01;
  localparam logic [7:0] CMD_SEND_TEXT_OP  = 8'h02;
  localparam logic [7:0] CMD_READ_MATCH_OP = 8'h03;
  localparam logic [7:0] CMD_TEST_OP       = 8'h04;

  localparam logic [7:0] ACK_VAL  = 8'h01;
  localparam logic [7:0] NACK_VAL = 8'h00;

  localparam int unsigned HASH_BYTES = 16;
  localparam int unsigned RESP_MAX   = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HASH_RX,
    ST_LEN_MSB,
    ST_LEN_LSB,
    ST_TEXT_RX,
    ST_RESP
  } state_e;

  function automatic logic [RESP_MAX*8-1:0] single_byte(input logic [7:0] b);
    logic [RESP_MAX*8-1:0] r;
    r      = '0;
    r[7:0] = b;
    return r;
  endfunction

endpackage

// File: rtl/uart_cmd_parser_tx_resp_queue.sv
// Response byte queue: loads up to RESP_MAX bytes (byte 0 sent first) and
// serialises them through the tx_start/tx_busy handshake, then pulses done.
module tx_resp_queue
  import top_md5_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4:0]            load_count,
  input  logic [RESP_MAX*8-1:0] load_data,
  input  logic                  tx_busy,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  output logic                  done
);

  logic [7:0] buf_q [RESP_MAX];
  logic [7:0] buf_d [RESP_MAX];
  logic [4:0] count_q, count_d;
  logic [4:0] idx_q, idx_d;
  logic       active_q, active_d;
  logic       gap_q, gap_d;
  logic       tx_start_q, tx_start_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       done_c;

  always_comb begin
    buf_d      = buf_q;
    count_d    = count_q;
    idx_d      = idx_q;
    active_d   = active_q;
    gap_d      = 1'b0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    done_c     = 1'b0;
    if (load) begin
      for (int unsigned i = 0; i < RESP_MAX; i++) buf_d[i] = load_data[8*i +: 8];
      count_d  = load_count;
      idx_d    = '0;
      active_d = 1'b1;
    end else if (active_q && !gap_q) begin
      // gap_q skips one busy sample after each pulse, covering the
      // transmitter's busy-assert latency.
      if (idx_q != count_q) begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = buf_q[idx_q[3:0]];
          idx_d      = idx_q + 5'd1;
          gap_d      = 1'b1;
        end
      end else begin
        done_c   = 1'b1;
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < RESP_MAX; i++) buf_q[i] <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      active_q   <= 1'b0;
      gap_q      <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      buf_q      <= buf_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      active_q   <= active_d;
      gap_q      <= gap_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign done     = done_c;

endmodule

// File: rtl/uart_cmd_parser.sv
// Host byte-protocol decoder: SET_HASH, SEND_TEXT, READ_MATCH and TEST
// commands, answered through tx_resp_queue.
module uart_cmd_parser
  import top_md5_pkg::*;
#(
  parameter int unsigned CLK_FREQUENCY  = 100_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0]  ACK_BYTE       = ACK_VAL,
  parameter logic [7:0]  NACK_BYTE      = NACK_VAL,
  parameter int unsigned TEST_LEN       = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rx_ready,
  input  logic [7:0]   rx_data,
  input  logic         tx_busy,
  output logic         tx_start,
  output logic [7:0]   tx_data,
  output logic [127:0] target_hash,
  output logic         hash_valid,
  output logic         text_valid,
  output logic [7:0]   text_data,
  output logic         text_last,
  input  logic         text_ready,
  input  logic         match_found,
  input  logic [15:0]  match_pos
);

  // Counter is wide enough for a full second as well as the configured limit.
  localparam int unsigned TMO_SPAN = (TIMEOUT_CYCLES > CLK_FREQUENCY) ? TIMEOUT_CYCLES : CLK_FREQUENCY;
  localparam int unsigned TMO_W    = $clog2(TMO_SPAN + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam int unsigned SHIFT_W  = (HASH_BYTES - 1) * 8;

  state_e               state_q, state_d;
  logic [SHIFT_W-1:0]   shift_q, shift_d;
  logic [3:0]           byte_cnt_q, byte_cnt_d;
  logic [15:0]          len_q, len_d;
  logic [15:0]          text_cnt_q, text_cnt_d;
  logic                 err_q, err_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [127:0]         target_hash_q, target_hash_d;
  logic                 hash_valid_q, hash_valid_d;
  logic                 text_valid_q, text_valid_d;
  logic [7:0]           text_data_q, text_data_d;
  logic                 text_last_q, text_last_d;

  logic                  timeout;
  logic                  q_load, q_done;
  logic [4:0]            q_count;
  logic [RESP_MAX*8-1:0] q_data;
  logic [15:0]           len_new;

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    byte_cnt_d    = byte_cnt_q;
    len_d         = len_q;
    text_cnt_d    = text_cnt_q;
    err_d         = err_q;
    tmo_d         = tmo_q;
    target_hash_d = target_hash_q;
    hash_valid_d  = hash_valid_q;
    text_valid_d  = 1'b0;
    text_data_d   = text_data_q;
    text_last_d   = 1'b0;
    timeout       = 1'b0;
    q_load        = 1'b0;
    q_count       = '0;
    q_data        = '0;
    len_new       = {len_q[15:8], rx_data};

    if (text_valid_q && !text_ready) err_d = 1'b1;

    if (state_q inside {ST_HASH_RX, ST_LEN_MSB, ST_LEN_LSB, ST_TEXT_RX}) begin
      if (rx_ready)              tmo_d = '0;
      else if (tmo_q == TMO_LAST) timeout = 1'b1;
      else                        tmo_d = tmo_q + 1'b1;
    end else begin
      tmo_d = '0;
    end

    case (state_q)
      ST_IDLE: begin
        err_d      = 1'b0;
        byte_cnt_d = '0;
        text_cnt_d = '0;
        if (rx_ready) begin
          case (rx_data)
            CMD_SET_HASH_OP:  state_d = ST_HASH_RX;
            CMD_SEND_TEXT_OP: state_d = ST_LEN_MSB;
            CMD_READ_MATCH_OP: begin
              q_load       = 1'b1;
              q_count      = 5'd3;
              q_data[7:0]  = {7'b0, match_found};
              q_data[15:8] = match_pos[15:8];
              q_data[23:16] = match_pos[7:0];
              state_d      = ST_RESP;
            end
            CMD_TEST_OP: begin
              q_load  = 1'b1;
              q_count = 5'(TEST_LEN);
              for (int unsigned i = 0; i < TEST_LEN; i++) q_data[8*i +: 8] = 8'(TEST_LEN - i);
              state_d = ST_RESP;
            end
            default: ;
          endcase
        end
      end
      ST_HASH_RX: begin
        if (timeout) begin
          q_load = 1'b1; q_count = 5'd1; q_data = single_byte(NACK_BYTE);
          state_d = ST_RESP;
        end else if (rx_ready) begin
          shift_d    = {shift_q[SHIFT_W-9:0], rx_data};
          byte_cnt_d = byte_cnt_q + 4'd1;
          if (byte_cnt_q == 4'(HASH_BYTES - 1)) begin
            target_hash_d = {shift_q, rx_data};
            hash_valid_d  = 1'b1;
            q_load = 1'b1; q_count = 5'd1; q_data = single_byte(ACK_BYTE);
            state_d = ST_RESP;
          end
        end
      end
      ST_LEN_MSB: begin
        if (timeout) begin
          q_load = 1'b1; q_count = 5'd1; q_data = single_byte(NACK_BYTE);
          state_d = ST_RESP;
        end else if (rx_ready) begin
          len_d[15:8] = rx_data;
          state_d     = ST_LEN_LSB;
        end
      end
      ST_LEN_LSB: begin
        if (timeout) begin
          q_load = 1'b1; q_count = 5'd1; q_data = single_byte(NACK_BYTE);
          state_d = ST_RESP;
        end else if (rx_ready) begin
          len_d = len_new;
          if (len_new == '0) begin
            q_load = 1'b1; q_count = 5'd1; q_data = single_byte(ACK_BYTE);
            state_d = ST_RESP;
          end else begin
            state_d = ST_TEXT_RX;
          end
        end
      end
      ST_TEXT_RX: begin
        // The verdict waits for the final byte's own ready sample.
        if (text_valid_q && text_last_q) begin
          q_load  = 1'b1;
          q_count = 5'd1;
          q_data  = single_byte((err_q || !text_ready) ? NACK_BYTE : ACK_BYTE);
          state_d = ST_RESP;
        end else if (timeout) begin
          q_load = 1'b1; q_count = 5'd1; q_data = single_byte(NACK_BYTE);
          state_d = ST_RESP;
        end else if (rx_ready && text_cnt_q != len_q) begin
          text_valid_d = 1'b1;
          text_data_d  = rx_data;
          text_cnt_d   = text_cnt_q + 16'd1;
          text_last_d  = (text_cnt_q + 16'd1 == len_q);
        end
      end
      ST_RESP: begin
        if (q_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      shift_q       <= '0;
      byte_cnt_q    <= '0;
      len_q         <= '0;
      text_cnt_q    <= '0;
      err_q         <= 1'b0;
      tmo_q         <= '0;
      target_hash_q <= '0;
      hash_valid_q  <= 1'b0;
      text_valid_q  <= 1'b0;
      text_data_q   <= '0;
      text_last_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      byte_cnt_q    <= byte_cnt_d;
      len_q         <= len_d;
      text_cnt_q    <= text_cnt_d;
      err_q         <= err_d;
      tmo_q         <= tmo_d;
      target_hash_q <= target_hash_d;
      hash_valid_q  <= hash_valid_d;
      text_valid_q  <= text_valid_d;
      text_data_q   <= text_data_d;
      text_last_q   <= text_last_d;
    end
  end

  tx_resp_queue u_tx_resp_queue (
    .clk        (clk),
    .reset      (reset),
    .load       (q_load),
    .load_count (q_count),
    .load_data  (q_data),
    .tx_busy    (tx_busy),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .done       (q_done)
  );

  assign target_hash = target_hash_q;
  assign hash_valid  = hash_valid_q;
  assign text_valid  = text_valid_q;
  assign text_data   = text_data_q;
  assign text_last   = text_last_q;

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
Command front end of top_md5, sitting directly downstream of async_receiver and upstream of async_transmitter and the string-match/MD5 datapath. It decodes the host byte protocol into the following actions:
- SET_HASH: latch the target hash.
- SEND_TEXT: stream length-prefixed text bytes to the match engine.
- READ_MATCH: report the match result.
- TEST: emit a fixed pattern.
Each command ends with ACK/NACK or response bytes serialised onto the UART transmitter.

Parameters:
CLK_FREQUENCY, 100_000_000, system clock Hz (sizes timeout counter)
TIMEOUT_CYCLES, 1_000_000, max idle cycles between bytes inside a command
ACK_BYTE, 8'h01, success response
NACK_BYTE, 8'h00, failure response
TEST_LEN, 10, TEST pattern length (bytes TEST_LEN down to 1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
rx_ready  in  1  one-cycle strobe, rx_data valid
rx_data  in  8  received byte
tx_busy  in  1  transmitter busy
tx_start  out  1  one-cycle send strobe
tx_data  out  8  byte to send, stable while tx_start high
target_hash  out  128  latched hash, first byte received in [127:120]
hash_valid  out  1  high after a complete SET_HASH
text_valid  out  1  one-cycle strobe per text byte
text_data  out  8  text byte
text_last  out  1  with text_valid on final byte
text_ready  in  1  consumer can accept (sampled at text_valid)
match_found  in  1  match engine result flag
match_pos  in  16  byte offset of match

Behaviour:
- Reset values: tx_start=0, tx_data=0, target_hash=0, hash_valid=0, text_valid=0, text_data=0, text_last=0; FSM=IDLE. Reset mid-command aborts it with no response sent.
- Opcodes: 01 SET_HASH, 02 SEND_TEXT, 03 READ_MATCH, 04 TEST. Any other byte in IDLE is silently dropped.
- FSM states and transitions:
  - IDLE.
  - HASH_RX: 16 bytes, MSB first; shifted into a staging register. target_hash and hash_valid update only after byte 16, then ACK.
  - LEN_MSB, then LEN_LSB: form a 16-bit length.
  - TEXT_RX:
    - Each rx_ready produces text_valid/text_data on the next cycle (1-cycle latency).
    - text_last is asserted on byte number len.
    - Length 0 skips TEXT_RX and ACKs immediately.
  - RESP: the response queue drains, then the FSM returns to IDLE.
- Overflow: text_ready=0 while text_valid is high sets a sticky err flag. The stream continues to completion, then NACK instead of ACK; err clears on entry to IDLE.
- Timeout:
  - Counter resets on every rx_ready and runs in every state except IDLE and RESP.
  - Reaching TIMEOUT_CYCLES sends NACK and returns to IDLE.
  - Partial hash is discarded; any text in flight has text_last suppressed.
- READ_MATCH response: 3 bytes, {7'b0,match_found}, match_pos[15:8], match_pos[7:0]. Inputs are sampled on the cycle the opcode is decoded.
- TEST response: bytes TEST_LEN, TEST_LEN-1, …, 1.
- TX handshake:
  - tx_start pulses one cycle only when tx_busy=0 and the queue is non-empty.
  - After a pulse, the queue waits one cycle before re-sampling tx_busy, which covers the transmitter's busy-assert latency.
- Bytes arriving during RESP are dropped; the host must wait for the response.
- hash_valid stays high until reset or the next completed SET_HASH.

Decomposition:
- Shared package top_md5_pkg:
  - opcode localparams CMD_SET_HASH_OP..CMD_TEST_OP
  - ACK/NACK values
  - state encoding
  - HASH_BYTES=16
- One sub-module, tx_resp_queue:
  - Loads up to 16 bytes (count + parallel data) from the FSM.
  - Serialises them with the tx_start/tx_busy handshake.
  - Returns a done pulse.

Test Plan:
- Reset, send 01 + A2 00 4F 37 73 0B 94 45 67 0A 73 8F A0 FC 9E E5 -> target_hash=a2004f37730b9445670a738fa0fc9ee5, hash_valid=1, single response byte 01.
- Send 02 00 64 + 100 bytes "abc…" with text_ready=1 -> exactly 100 text_valid pulses, data in order, text_last only on the 100th, then response 01.
- SEND_TEXT len 5 with text_ready forced 0 on byte 3 -> 5 text_valid pulses still occur, response 00, next command decodes normally.
- Set match_found=1, match_pos=16'h1234, send 03 -> response bytes 01 12 34.
- Send 04 -> response 0A 09 … 01 (10 bytes); bench stops on 01.
- Send 01 + 5 hash bytes then go silent -> NACK 00 after TIMEOUT_CYCLES, target_hash unchanged, hash_valid unchanged. Repeat with reset asserted mid-hash -> no response, all outputs back to reset values.
